// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - in-order load/store initiator with request FIFO, load extension and byte/half read-modify-write
module lsu_mem_master #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int MEM_BYTES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_we,
    input  logic [2:0]       i_req_funct3,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_err,
    output logic             o_busy,
    output logic [31:0]      o_MemAddr,
    output logic [31:0]      o_MemWD,
    output logic             o_MemWE,
    input  logic [31:0]      i_MemRD
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, RMW_WR} state_t;

    logic             q_we    [DEPTH];
    logic [2:0]       q_f3    [DEPTH];
    logic [31:0]      q_addr  [DEPTH];
    logic [31:0]      q_wdata [DEPTH];
    logic [TAG_W-1:0] q_tag   [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    state_t        state;
    logic [31:0]   merge;

    logic             full, empty, push, pop;
    logic             h_we;
    logic [2:0]       h_f3;
    logic [31:0]      h_addr, h_wdata;
    logic [TAG_W-1:0] h_tag;
    logic [32:0]      h_end;
    logic             addr_bad, f3_bad, h_bad, rsp_free, head_ok;
    logic             do_err, do_load, do_sw, do_rmw_rd;
    logic [31:0]      ld_ext, st_merge;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = i_req_valid & ~full;

    assign h_we    = q_we[rd_ptr];
    assign h_f3    = q_f3[rd_ptr];
    assign h_addr  = q_addr[rd_ptr];
    assign h_wdata = q_wdata[rd_ptr];
    assign h_tag   = q_tag[rd_ptr];

    // 33-bit sum so addresses near 2^32 cannot wrap into the legal range
    assign h_end    = {1'b0, h_addr} + 33'd3;
    assign addr_bad = (h_end >= 33'(MEM_BYTES));
    assign f3_bad   = h_we ? (h_f3[2] | (h_f3[1:0] == 2'b11))
                           : ((h_f3 == 3'b011) | (h_f3[2:1] == 2'b11));
    assign h_bad    = addr_bad | f3_bad;
    assign rsp_free = ~o_rsp_valid | i_rsp_ready;
    assign head_ok  = (state == IDLE) & ~empty & ~h_bad;

    assign do_err    = (state == IDLE) & ~empty & h_bad;
    assign do_load   = head_ok & ~h_we & rsp_free;
    assign do_sw     = head_ok & h_we & (h_f3 == 3'b010);
    assign do_rmw_rd = head_ok & h_we & (h_f3 != 3'b010);
    assign pop       = do_err | do_load | do_sw | (state == RMW_WR);

    always_comb begin
        ld_ext = i_MemRD;
        case (h_f3)
            3'b000:  ld_ext = {{24{i_MemRD[7]}}, i_MemRD[7:0]};
            3'b001:  ld_ext = {{16{i_MemRD[15]}}, i_MemRD[15:0]};
            3'b100:  ld_ext = {24'd0, i_MemRD[7:0]};
            3'b101:  ld_ext = {16'd0, i_MemRD[15:0]};
            default: ld_ext = i_MemRD;
        endcase
    end

    assign st_merge = h_f3[0] ? {i_MemRD[31:16], h_wdata[15:0]}
                              : {i_MemRD[31:8],  h_wdata[7:0]};

    assign o_req_ready = ~full;
    assign o_busy      = ~empty | (state != IDLE);
    assign o_MemAddr   = h_addr;
    assign o_MemWD     = (state == RMW_WR) ? merge : h_wdata;
    // Reset gates the strobe directly so an interrupted RMW never writes
    assign o_MemWE     = ~rst & (do_sw | (state == RMW_WR));

    always_ff @(posedge clk) begin
        if (push) begin
            q_we[wr_ptr]    <= i_req_we;
            q_f3[wr_ptr]    <= i_req_funct3;
            q_addr[wr_ptr]  <= i_req_addr;
            q_wdata[wr_ptr] <= i_req_wdata;
            q_tag[wr_ptr]   <= i_req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            state       <= IDLE;
            merge       <= '0;
            o_err       <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_tag   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            o_err <= do_err;

            if (do_load) begin
                o_rsp_valid <= 1'b1;
                o_rsp_data  <= ld_ext;
                o_rsp_tag   <= h_tag;
            end else if (i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (do_rmw_rd) begin
                        merge <= st_merge;
                        state <= RMW_WR;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed vector bench for lsu_mem_master with a byte memory model
module tb_lsu_mem_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_we, i_rsp_ready;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr, i_req_wdata;
    logic [3:0]  i_req_tag;
    logic        o_req_ready, o_rsp_valid, o_err, o_busy, o_MemWE;
    logic [31:0] o_rsp_data, o_MemAddr, o_MemWD, i_MemRD;
    logic [3:0]  o_rsp_tag;

    always #5 clk = ~clk;

    lsu_mem_master #(.DEPTH(4), .TAG_W(4), .MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_tag(i_req_tag),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_data(o_rsp_data), .o_rsp_tag(o_rsp_tag),
        .o_err(o_err), .o_busy(o_busy),
        .o_MemAddr(o_MemAddr), .o_MemWD(o_MemWD), .o_MemWE(o_MemWE), .i_MemRD(i_MemRD)
    );

    logic [7:0] mem [256];
    logic       mem_inited = 1'b0;
    logic [7:0] ma;

    assign ma = o_MemAddr[7:0];
    always_comb i_MemRD = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem_inited <= 1'b1;
        end else if (o_MemWE) begin
            mem[ma]         <= o_MemWD[7:0];
            mem[ma + 8'd1]  <= o_MemWD[15:8];
            mem[ma + 8'd2]  <= o_MemWD[23:16];
            mem[ma + 8'd3]  <= o_MemWD[31:24];
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  tag;
        logic        exp_rsp;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_wr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] tag, input logic exp_rsp,
                       input logic [31:0] exp_data, input logic exp_err, input logic exp_wr,
                       input int exp_lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.tag = tag;
        v.exp_rsp = exp_rsp; v.exp_data = exp_data; v.exp_err = exp_err;
        v.exp_wr = exp_wr; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] tag);
        i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3;
        i_req_addr = addr; i_req_wdata = wdata; i_req_tag = tag;
    endtask

    int          rsp_cyc, err_cnt, err_cyc, wr_cyc, act_lat, waited;
    logic        wr_seen;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [3:0]  tags[$];

    initial begin
        rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_funct3 = 3'b000;
        i_req_addr = '0; i_req_wdata = '0; i_req_tag = '0; i_rsp_ready = 1'b1;

        //   we  f3      addr   wdata          tag  rsp  data           err  wr   lat
        add(1, 3'b010, 32'h10, 32'hDEADBEEF, 4'h0, 0, 32'h0,          0,   1,   1);
        add(0, 3'b010, 32'h10, 32'h0,        4'h3, 1, 32'hDEADBEEF,   0,   0,   2);
        add(1, 3'b000, 32'h11, 32'h00000055, 4'h0, 0, 32'h0,          0,   1,   2);
        add(0, 3'b000, 32'h11, 32'h0,        4'h1, 1, 32'h00000055,   0,   0,   2);
        add(0, 3'b010, 32'h10, 32'h0,        4'h2, 1, 32'hDEAD55EF,   0,   0,   2);
        add(1, 3'b001, 32'h12, 32'h00008001, 4'h0, 0, 32'h0,          0,   1,   2);
        add(0, 3'b001, 32'h12, 32'h0,        4'h4, 1, 32'hFFFF8001,   0,   0,   2);
        add(0, 3'b101, 32'h12, 32'h0,        4'h5, 1, 32'h00008001,   0,   0,   2);
        add(0, 3'b000, 32'h13, 32'h0,        4'h6, 1, 32'hFFFFFF80,   0,   0,   2);
        add(0, 3'b100, 32'h13, 32'h0,        4'h7, 1, 32'h00000080,   0,   0,   2);
        add(0, 3'b010, 32'hFD, 32'h0,        4'h8, 0, 32'h0,          1,   0,   2);
        add(0, 3'b010, 32'hFC, 32'h0,        4'h9, 1, 32'h00000000,   0,   0,   2);
        add(1, 3'b100, 32'h40, 32'h00000001, 4'h0, 0, 32'h0,          1,   0,   2);
        add(0, 3'b011, 32'h10, 32'h0,        4'hA, 0, 32'h0,          1,   0,   2);
        add(0, 3'b010, 32'h10, 32'h0,        4'hB, 1, 32'h800155EF,   0,   0,   2);
        add(1, 3'b010, 32'hFC, 32'h12345678, 4'h0, 0, 32'h0,          0,   1,   1);
        add(0, 3'b010, 32'hFC, 32'h0,        4'hC, 1, 32'h12345678,   0,   0,   2);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("reset_err",       {31'd0, o_err},       32'd0);
        chk("reset_busy",      {31'd0, o_busy},      32'd0);
        chk("reset_memwe",     {31'd0, o_MemWE},     32'd0);

        foreach (vecs[i]) begin
            drive_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
            waited = 0;
            while (!o_req_ready && waited < 20) begin @(negedge clk); waited++; end
            chk($sformatf("v%0d_accept", i), {31'd0, o_req_ready}, 32'd1);
            rsp_cyc = 0; err_cnt = 0; err_cyc = 0; wr_cyc = 0; wr_seen = 1'b0;
            rsp_data = '0; rsp_tag = '0;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                if (c == 1) i_req_valid = 1'b0;
                if (o_rsp_valid && rsp_cyc == 0) begin
                    rsp_cyc = c; rsp_data = o_rsp_data; rsp_tag = o_rsp_tag;
                end
                if (o_err) begin err_cnt++; if (err_cyc == 0) err_cyc = c; end
                if (o_MemWE) begin wr_seen = 1'b1; if (wr_cyc == 0) wr_cyc = c; end
            end
            chk($sformatf("v%0d_rsp_seen", i), {31'd0, rsp_cyc != 0}, {31'd0, vecs[i].exp_rsp});
            if (vecs[i].exp_rsp) begin
                chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
                chk($sformatf("v%0d_rsp_tag", i), {28'd0, rsp_tag}, {28'd0, vecs[i].tag});
            end
            chk($sformatf("v%0d_err_pulses", i), err_cnt, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_write", i), {31'd0, wr_seen}, {31'd0, vecs[i].exp_wr});
            if (vecs[i].exp_err)  act_lat = err_cyc;
            else if (!vecs[i].we) act_lat = rsp_cyc;
            else                  act_lat = wr_cyc;
            chk($sformatf("v%0d_latency", i), act_lat, vecs[i].exp_lat);
            if (i == 0)
                chk("sw_bytes", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
        end

        // Response register held by tag A blocks the FIFO: four more fit, the fifth is refused.
        i_rsp_ready = 1'b0;
        drive_req(1'b0, 3'b010, 32'h10, 32'h0, 4'hA);
        @(negedge clk);
        i_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_hold_valid", {31'd0, o_rsp_valid}, 32'd1);
        chk("bp_hold_tag", {28'd0, o_rsp_tag}, 32'hA);
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("bp_ready_%0d", t), {31'd0, o_req_ready}, {31'd0, t < 4});
            drive_req(1'b0, 3'b010, 32'h10, 32'h0, 4'(t));
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        chk("bp_stable_tag", {28'd0, o_rsp_tag}, 32'hA);
        chk("bp_stable_data", o_rsp_data, 32'h800155EF);
        for (int j = 0; j < 12; j++) begin
            if (o_rsp_valid) tags.push_back(o_rsp_tag);
            if (j == 0) i_rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk("bp_rsp_count", tags.size(), 32'd5);
        for (int j = 0; j < 5; j++)
            chk($sformatf("bp_order_%0d", j), (j < tags.size()) ? {28'd0, tags[j]} : 32'hFFFFFFFF,
                (j == 0) ? 32'hA : 32'(j - 1));
        chk("bp_idle", {31'd0, o_busy}, 32'd0);

        // Reset lands in the RMW write cycle of a byte store.
        drive_req(1'b1, 3'b000, 32'h20, 32'h00000077, 4'h0);
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("rmw_read_no_we", {31'd0, o_MemWE}, 32'd0);
        @(negedge clk);
        chk("rmw_wr_we", {31'd0, o_MemWE}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_blocks_we", {31'd0, o_MemWE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_unchanged", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}, 32'h0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, o_req_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
